// File: rtl/rn_window_pkg.sv
// Shared types and width helpers for the radius-N window controller.
package rn_window_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ROW_START,
    S_SUM,
    S_CUM,
    S_FINISH
  } state_e;

  function automatic int win_w(input int r);
    return 2 * r + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rn_pos_counter.sv
// Column/row position counter; column wraps at COLS-1 and bumps the row.
module rn_pos_counter #(
  parameter int COLS = 15,
  parameter int CW   = 4,
  parameter int RW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_col_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_col_last,
  output logic          o_row_inc
);

  localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_col_last = (r_col == LastCol);
  assign o_row_inc  = i_inc & o_col_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (i_col_clr)
        r_col <= '0;
      else if (i_inc)
        r_col <= o_col_last ? '0 : r_col + 1'b1;
      if (o_row_inc)
        r_row <= r_row + 1'b1;
    end
  end

endmodule

// File: rtl/rn_window_ctrl.sv
// Frame-level enable sequencer for the radius-N sliding-window stages.
module rn_window_ctrl
  import rn_window_pkg::*;
#(
  parameter int RADIUS   = 6,
  parameter int COLS     = 15,
  parameter int ROWS     = 15,
  parameter int FLUSH_EN = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic                            ld_en,
  output logic                            sum_en,
  output logic                            cum_en,
  output logic                            count_en,
  output logic                            flush_o,
  output logic                            done_o,
  output logic                            progress_done,
  output logic [$clog2(COLS)-1:0]         col_o,
  output logic [$clog2(ROWS+RADIUS)-1:0]  row_o
);

  localparam int CW      = cnt_w(COLS);
  localparam int RW      = cnt_w(ROWS + RADIUS);
  localparam int W       = win_w(RADIUS);
  localparam int LastRow = (FLUSH_EN != 0) ? ROWS + RADIUS - 1 : ROWS - 1;

  state_e r_state, w_next;
  logic   r_flush, w_flush_nxt;

  logic          w_stream, w_beat, w_clr;
  logic          w_col_last, w_row_inc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_row_last, w_prime_end;
  logic          w_sum_end, w_flush_row;

  assign w_stream = (r_state == S_PRIME) ||
                    (r_state == S_SUM) ||
                    (r_state == S_CUM);
  // Border beats are self-timed: upstream data is not consumed.
  assign w_beat   = w_stream & (r_flush | valid_i);
  assign w_clr    = ((r_state == S_IDLE) & start_i) ||
                    (r_state == S_FINISH);

  rn_pos_counter #(
    .COLS (COLS),
    .CW   (CW),
    .RW   (RW)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_col_clr  (r_state == S_ROW_START),
    .i_inc      (w_beat),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_col_last (w_col_last),
    .o_row_inc  (w_row_inc)
  );

  assign w_row_last  = (w_row == RW'(LastRow));
  assign w_prime_end = (w_row == RW'(2 * RADIUS - 1));
  assign w_sum_end   = (w_col == CW'(W - 2));
  assign w_flush_row = (FLUSH_EN != 0) &&
                       (w_row == RW'(ROWS - 1));

  assign ready_o       = w_stream & ~r_flush;
  assign ld_en         = (r_state == S_ROW_START);
  assign progress_done = (r_state == S_FINISH);
  assign sum_en        = w_beat & (r_state == S_SUM);
  assign cum_en        = w_beat & (r_state == S_CUM);
  assign done_o        = cum_en;
  assign count_en      = w_beat;
  assign flush_o       = w_beat & r_flush;
  assign col_o         = w_col;
  assign row_o         = w_row;

  always_comb begin
    w_next      = r_state;
    w_flush_nxt = r_flush;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next      = S_PRIME;
          w_flush_nxt = 1'b0;
        end
      end
      S_PRIME: begin
        if (w_row_inc && w_prime_end)
          w_next = S_ROW_START;
      end
      S_ROW_START: w_next = S_SUM;
      S_SUM: begin
        if (w_beat && w_sum_end)
          w_next = S_CUM;
      end
      S_CUM: begin
        if (w_row_inc) begin
          if (w_row_last) begin
            w_next = S_FINISH;
          end else begin
            w_next = S_ROW_START;
            if (w_flush_row)
              w_flush_nxt = 1'b1;
          end
        end
      end
      S_FINISH: begin
        w_next      = S_IDLE;
        w_flush_nxt = 1'b0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= w_flush_nxt;
    end
  end

endmodule

// File: tb/tb_rn_window_ctrl.sv
// Bench for rn_window_ctrl: frame-token model plus directed frame scenarios.
module tb_rn_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid;
  logic [2:0] st;

  logic [2:0] rdy, ld, sm, cm, ce, fo, dn, pd;
  logic [1:0] col0, col1;
  logic [3:0] col2;
  logic [2:0] row0, row1;
  logic [4:0] row2;

  rn_window_ctrl #(.RADIUS(1), .COLS(4), .ROWS(4), .FLUSH_EN(0)) u0 (
    .clk(clk), .rst(rst), .start_i(st[0]), .valid_i(valid),
    .ready_o(rdy[0]), .ld_en(ld[0]), .sum_en(sm[0]), .cum_en(cm[0]),
    .count_en(ce[0]), .flush_o(fo[0]), .done_o(dn[0]),
    .progress_done(pd[0]), .col_o(col0), .row_o(row0));

  rn_window_ctrl #(.RADIUS(1), .COLS(4), .ROWS(4), .FLUSH_EN(1)) u1 (
    .clk(clk), .rst(rst), .start_i(st[1]), .valid_i(valid),
    .ready_o(rdy[1]), .ld_en(ld[1]), .sum_en(sm[1]), .cum_en(cm[1]),
    .count_en(ce[1]), .flush_o(fo[1]), .done_o(dn[1]),
    .progress_done(pd[1]), .col_o(col1), .row_o(row1));

  rn_window_ctrl #(.RADIUS(6), .COLS(15), .ROWS(15), .FLUSH_EN(0)) u2 (
    .clk(clk), .rst(rst), .start_i(st[2]), .valid_i(valid),
    .ready_o(rdy[2]), .ld_en(ld[2]), .sum_en(sm[2]), .cum_en(cm[2]),
    .count_en(ce[2]), .flush_o(fo[2]), .done_o(dn[2]),
    .progress_done(pd[2]), .col_o(col2), .row_o(row2));

  typedef enum {K_PRIME, K_LD, K_SUM, K_CUM, K_FIN} kind_e;
  typedef struct {
    kind_e k;
    int    col;
    int    row;
    bit    fl;
  } tok_t;

  tok_t q[$];
  int   sel;
  int   n_vec, n_err;
  int   n_done, n_ld, n_beat, n_pd, n_fbeat, n_fdone, n_cyc, n_nov;

  // Expected frame as an ordered list of cycles/beats.
  function automatic void build(int r, int cols, int rows, bit fe);
    tok_t t;
    int   last;
    q.delete();
    for (int y = 0; y < 2 * r; y++)
      for (int x = 0; x < cols; x++) begin
        t = '{K_PRIME, x, y, 1'b0};
        q.push_back(t);
      end
    last = fe ? rows + r - 1 : rows - 1;
    for (int y = 2 * r; y <= last; y++) begin
      t = '{K_LD, 0, y, 1'b0};
      q.push_back(t);
      for (int x = 0; x < cols; x++) begin
        t = '{(x < 2 * r) ? K_SUM : K_CUM, x, y, (y >= rows)};
        q.push_back(t);
      end
    end
    t = '{K_FIN, 0, 0, 1'b0};
    q.push_back(t);
  endfunction

  function automatic logic [7:0] flags();
    return {rdy[sel], ld[sel], sm[sel], cm[sel],
            ce[sel], fo[sel], dn[sel], pd[sel]};
  endfunction

  function automatic int col_of();
    case (sel)
      0:       return int'(col0);
      1:       return int'(col1);
      default: return int'(col2);
    endcase
  endfunction

  function automatic int row_of();
    case (sel)
      0:       return int'(row0);
      1:       return int'(row1);
      default: return int'(row2);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  // Model step: bits {ready,ld,sum,cum,count,flush,done,pdone}.
  task automatic step();
    logic [7:0] act, exp;
    bit         beat, empty;
    tok_t       t;
    act   = flags();
    exp   = '0;
    beat  = 1'b0;
    empty = (q.size() == 0);
    if (!empty) begin
      t = q[0];
      n_cyc++;
      case (t.k)
        K_LD:  exp[6] = 1'b1;
        K_FIN: exp[0] = 1'b1;
        default: begin
          beat   = t.fl || (valid === 1'b1);
          exp[7] = !t.fl;
          exp[5] = beat && (t.k == K_SUM);
          exp[4] = beat && (t.k == K_CUM);
          exp[3] = beat;
          exp[2] = beat && t.fl;
          exp[1] = beat && (t.k == K_CUM);
        end
      endcase
    end
    check("flags", 32'(act), 32'(exp));
    if (beat) begin
      check("col", col_of(), t.col);
      check("row", row_of(), t.row);
    end
    if (!empty && (beat || t.k == K_LD || t.k == K_FIN))
      void'(q.pop_front());
    n_done  += int'(act[1]);
    n_ld    += int'(act[6]);
    n_beat  += int'(act[3]);
    n_pd    += int'(act[0]);
    n_fbeat += int'(act[3] & act[2]);
    n_fdone += int'(act[1] & act[2]);
    if (valid !== 1'b1 && !act[2] &&
        (act[5] | act[4] | act[3] | act[1]))
      n_nov++;
    if (rst) begin
      q.delete();
    end else if (empty && st[sel]) begin
      case (sel)
        0:       build(1, 4, 4, 1'b0);
        1:       build(1, 4, 4, 1'b1);
        default: build(6, 15, 15, 1'b0);
      endcase
      n_done = 0; n_ld = 0; n_beat = 0; n_pd = 0;
      n_fbeat = 0; n_fdone = 0; n_cyc = 0; n_nov = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    st[sel] = 1'b1;
    cycle();
    st = '0;
  endtask

  task automatic wait_idle(int budget, bit randv);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      if (randv) valid = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (q.size() > 0) begin
      check("frame_timeout", q.size(), 0);
      q.delete();
    end
    valid = 1'b1;
  endtask

  int a_done, a_cyc;

  initial begin
    n_vec = 0; n_err = 0; sel = 0;
    n_done = 0; n_ld = 0; n_beat = 0; n_pd = 0;
    n_fbeat = 0; n_fdone = 0; n_cyc = 0; n_nov = 0;
    rst = 1'b1; valid = 1'b1; st = '0;
    #1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("reset_flags", 32'(flags()), 0);
    check("reset_col", col_of(), 0);
    check("reset_row", row_of(), 0);

    // R=1 4x4, no flush
    sel = 0;
    start_pulse();
    wait_idle(200, 1'b0);
    check("f0_done", n_done, 4);
    check("f0_ld", n_ld, 2);
    check("f0_beats", n_beat, 16);
    check("f0_pdone", n_pd, 1);
    check("f0_cycles", n_cyc, 19);
    repeat (2) cycle();

    // R=1 4x4 with bottom flush
    sel = 1;
    start_pulse();
    wait_idle(200, 1'b0);
    check("f1_done", n_done, 6);
    check("f1_flush_done", n_fdone, 2);
    check("f1_flush_beats", n_fbeat, 4);
    check("f1_cycles", n_cyc, 24);
    repeat (2) cycle();

    // R=6 15x15 with 50% valid
    sel = 2;
    start_pulse();
    wait_idle(3000, 1'b1);
    check("r6_done", n_done, 9);
    check("r6_novalid_en", n_nov, 0);
    check("r6_pdone", n_pd, 1);
    repeat (2) cycle();

    // reset on the third cumulative beat
    sel = 0;
    start_pulse();
    repeat (16) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_at_cum3", n_done, 3);
    check("rst_idle_flags", 32'(flags()), 0);
    check("rst_pdone", n_pd, 0);
    repeat (2) cycle();
    start_pulse();
    wait_idle(200, 1'b0);
    check("restart_done", n_done, 4);
    repeat (2) cycle();

    // stray start pulses in PRIME and CUM
    start_pulse();
    repeat (3) cycle();
    start_pulse();
    repeat (7) cycle();
    start_pulse();
    wait_idle(200, 1'b0);
    check("stray_done", n_done, 4);
    check("stray_beats", n_beat, 16);
    check("stray_cycles", n_cyc, 19);
    repeat (2) cycle();

    // back-to-back frames
    start_pulse();
    wait_idle(200, 1'b0);
    a_done = n_done;
    a_cyc  = n_cyc;
    start_pulse();
    wait_idle(200, 1'b0);
    check("b2b_a_done", a_done, 4);
    check("b2b_a_cycles", a_cyc, 19);
    check("b2b_b_done", n_done, 4);
    check("b2b_b_cycles", n_cyc, 19);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
